// File: rtl/matmul_result_drain_if.sv
// Stream bundle between the matmul accumulator array, the result drain and
// its downstream consumer.
//
// Handshake rule for both streams: a word moves on a rising clk edge where
// valid && ready. Once the source raises valid, it holds valid and data
// steady until that transfer happens. ready may change freely, and it never
// depends on valid in the same cycle.
interface matmul_result_drain_if #(
    parameter int N     = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
);
    localparam int IDX_W = $clog2(N);

    // accumulator stream into the drain
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;

    // requantized, position-tagged stream out of the drain
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_row;
    logic [IDX_W-1:0] out_col;
    logic             out_last;

    // environment side: produces accumulators, consumes results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    // drain side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/matmul_result_drain.sv
// Result drain for the tiled sparse matmul engine. Each 32-bit accumulator
// is rounded (half-up), arithmetic-shifted and saturated to 16 bits. It is
// tagged with its global (row, col) in tile order and queued in a small
// FIFO that feeds a backpressured output stream. Input credit covers the
// FIFO plus the two pipeline stages, so the pipeline never has to stall.
module matmul_result_drain #(
    parameter int N          = 16,
    parameter int TILE       = 4,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            shift,
    matmul_result_drain_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           sat_count,
    output logic [1:0]            state_dbg
);
    localparam int IDX_W = $clog2(N);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = OUT_W + 2 * IDX_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
    localparam logic [IDX_W-1:0] TILE_LAST = IDX_W'(TILE - 1);
    localparam logic [IDX_W-1:0] BASE_LAST = IDX_W'(N - TILE);
    localparam logic [IDX_W-1:0] TILE_STEP = IDX_W'(TILE);

    // Saturation bounds in the widened (ACC_W+1) result domain
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]       state_q;
    logic [4:0]       shift_q;
    logic [IDX_W-1:0] tr_q, tc_q, ti_q, tj_q;

    logic             s1_valid;
    logic signed [ACC_W:0] s1_r;
    logic [IDX_W-1:0] s1_row, s1_col;
    logic             s1_last;

    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic [IDX_W-1:0] s2_row, s2_col;
    logic             s2_last;

    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic             start_acc;
    logic             accept;
    logic             idx_last;
    logic             pipe_empty;
    logic             push, pop;
    logic [CNT_W:0]   credit_used;
    logic [EW-1:0]    head;

    logic signed [ACC_W:0] s1_round, s1_sum, s1_res;
    logic             sat_hi, sat_lo;
    logic [OUT_W-1:0] s1_sat;

    // Handshake, credit and run-position decode
    always_comb begin
        start_acc   = (state_q == ST_IDLE) && start;
        credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid) + (CNT_W + 1)'(s2_valid);
        bus.in_ready = (state_q == ST_RUN) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        accept      = bus.in_valid && bus.in_ready;
        idx_last    = (tr_q == BASE_LAST) && (tc_q == BASE_LAST) &&
                      (ti_q == TILE_LAST) && (tj_q == TILE_LAST);
        pipe_empty  = !s1_valid && !s2_valid && (fifo_count == '0);
        push        = s2_valid;
        pop         = bus.out_valid && bus.out_ready;
    end

    // Run-control FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_q <= ST_RUN;
                ST_RUN:   if (accept && idx_last) state_q <= ST_FLUSH;
                ST_FLUSH: if (pipe_empty) state_q <= ST_DONE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Shift amount is frozen for the whole run at the accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (start_acc) begin
            shift_q <= shift;
        end
    end

    // Tile-order position counters: j fastest, then i, then tile column, then tile row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tr_q <= '0;
            tc_q <= '0;
            ti_q <= '0;
            tj_q <= '0;
        end else if (start_acc) begin
            tr_q <= '0;
            tc_q <= '0;
            ti_q <= '0;
            tj_q <= '0;
        end else if (accept) begin
            if (tj_q == TILE_LAST) begin
                tj_q <= '0;
                if (ti_q == TILE_LAST) begin
                    ti_q <= '0;
                    if (tc_q == BASE_LAST) begin
                        tc_q <= '0;
                        tr_q <= (tr_q == BASE_LAST) ? '0 : tr_q + TILE_STEP;
                    end else begin
                        tc_q <= tc_q + TILE_STEP;
                    end
                end else begin
                    ti_q <= ti_q + ONE_IDX;
                end
            end else begin
                tj_q <= tj_q + ONE_IDX;
            end
        end
    end

    // Round half-up then arithmetic shift; one extra bit keeps the add exact
    always_comb begin
        s1_round = '0;
        if (shift_q != 5'd0) begin
            s1_round = (ACC_W + 1)'(1) << (shift_q - 5'd1);
        end
        s1_sum = $signed({bus.in_data[ACC_W-1], bus.in_data}) + s1_round;
        s1_res = s1_sum >>> shift_q;
    end

    // Stage 1: register the rounded/shifted value with its position tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_r    <= s1_res;
                s1_row  <= tr_q + ti_q;
                s1_col  <= tc_q + tj_q;
                s1_last <= idx_last;
            end
        end
    end

    // Clamp the stage-1 value into the signed output range
    always_comb begin
        sat_hi = s1_r > SAT_MAX;
        sat_lo = s1_r < SAT_MIN;
        if (sat_hi) begin
            s1_sat = SAT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            s1_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            s1_sat = s1_r[OUT_W-1:0];
        end
    end

    // Stage 2: register the saturated element; it is pushed to the FIFO next edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_sat;
                s2_row  <= s1_row;
                s2_col  <= s1_col;
                s2_last <= s1_last;
            end
        end
    end

    // Saturation event counter, cleared when a new run starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count <= '0;
        end else if (start_acc) begin
            sat_count <= '0;
        end else if (s1_valid && (sat_hi || sat_lo)) begin
            sat_count <= sat_count + 32'd1;
        end
    end

    // FIFO storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s2_data, s2_row, s2_col, s2_last};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head presentation, forced to zero while the FIFO is empty
    always_comb begin
        bus.out_valid = (fifo_count != '0);
        head          = bus.out_valid ? fifo_mem[rd_ptr] : '0;
        bus.out_data  = head[EW-1 -: OUT_W];
        bus.out_row   = head[2*IDX_W -: IDX_W];
        bus.out_col   = head[IDX_W -: IDX_W];
        bus.out_last  = head[0];
        busy          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done          = (state_q == ST_DONE);
        state_dbg     = state_q;
    end
endmodule

// File: tb/tb_matmul_result_drain.sv
// Bench for matmul_result_drain: single-element vector table for rounding,
// saturation and latency, followed by streamed sequences for backpressure,
// reset mid-run and a full randomized run against a reference model.
module tb_matmul_result_drain;
    localparam int N          = 16;
    localparam int TILE       = 4;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = $clog2(N);
    localparam int EW         = OUT_W + 2 * IDX_W + 1;
    localparam int NVEC       = 12;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  shift = 5'd0;
    logic        busy, done;
    logic [31:0] sat_count;
    logic [1:0]  state_dbg;

    matmul_result_drain_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    matmul_result_drain #(
        .N(N), .TILE(TILE), .ACC_W(ACC_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .shift(shift),
        .bus(bus),
        .busy(busy),
        .done(done),
        .sat_count(sat_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: round half-up, arithmetic shift, clamp, tile-order tag
    function automatic logic [EW-1:0] model(input int k, input logic [ACC_W-1:0] d,
                                            input int sh, output bit sat);
        longint x;
        longint hi, lo;
        int tile, w, tr, tc;
        logic [OUT_W-1:0] v;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        x = longint'($signed(d));
        if (sh > 0) x = x + (longint'(1) <<< (sh - 1));
        x = x >>> sh;
        sat = 1'b0;
        if (x > hi) begin
            x = hi;
            sat = 1'b1;
        end else if (x < lo) begin
            x = lo;
            sat = 1'b1;
        end
        v = x[OUT_W-1:0];
        tile = k / (TILE * TILE);
        w = k % (TILE * TILE);
        tr = (tile / (N / TILE)) * TILE;
        tc = (tile % (N / TILE)) * TILE;
        return {v, IDX_W'(tr + w / TILE), IDX_W'(tc + w % TILE), (k == N * N - 1)};
    endfunction

    function automatic logic [31:0] small_word();
        logic [31:0] r;
        r = $urandom();
        return {{11{r[20]}}, r[20:0]};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] exp_q[$];
    bit            mon_en = 1'b0;
    int            cur_shift = 0;
    int            acc_idx, pops, model_sat, done_cnt, negcyc, last_pop_cyc, done_cyc;
    bit            hold_pending, prev_busy;
    logic [EW-1:0] held, tag4, tag16, tag255;

    always @(negedge clk) begin : monitor
        logic [EW-1:0] got, e;
        bit s;
        negcyc++;
        if (!mon_en) begin
            exp_q.delete();
            hold_pending = 1'b0;
            acc_idx = 0;
            pops = 0;
            model_sat = 0;
            done_cnt = 0;
            last_pop_cyc = 0;
            done_cyc = 0;
            prev_busy = 1'b0;
        end else begin
            got = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
            if (hold_pending) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_head", 64'(got), 64'(held));
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            held = got;
            if (bus.in_valid && bus.in_ready) begin
                e = model(acc_idx, bus.in_data, cur_shift, s);
                exp_q.push_back(e);
                if (s) model_sat++;
                acc_idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("out_has_expect", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("out_elem%0d", pops), 64'(got), 64'(e));
                end
                if (pops == 4)   tag4 = got;
                if (pops == 16)  tag16 = got;
                if (pops == 255) tag255 = got;
                pops++;
                last_pop_cyc = negcyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = negcyc;
                check("busy_fall_with_done", 64'({prev_busy, busy}), 64'd2);
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        mon_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_run(input int sh);
        cur_shift = sh;
        shift = 5'(sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        shift = 5'd17;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) check("send_word_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_data"},  64'(bus.out_data), 64'd0);
        check({tag, "_out_row"},   64'(bus.out_row), 64'd0);
        check({tag, "_out_col"},   64'(bus.out_col), 64'd0);
        check({tag, "_out_last"},  64'(bus.out_last), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_done"},      64'(done), 64'd0);
        check({tag, "_sat_count"}, 64'(sat_count), 64'd0);
        check({tag, "_state"},     64'(state_dbg), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  sh;
        logic [31:0] din;
        logic [15:0] dout;
        int          sat;
    } vec_t;

    vec_t vecs[NVEC];

    // ---------------- main sequence ----------------
    initial begin
        bit xfer;
        int accepts, sent, n, d;
        bit poked, poke_checked;

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{5'd1,  32'd5,          16'd3,       0};
        vecs[1]  = '{5'd1,  -32'sd5,        -16'sd2,     0};
        vecs[2]  = '{5'd1,  32'd4,          16'd2,       0};
        vecs[3]  = '{5'd0,  -32'sd7,        -16'sd7,     0};
        vecs[4]  = '{5'd0,  32'd40000,      16'h7fff,    1};
        vecs[5]  = '{5'd0,  -32'sd40000,    16'h8000,    1};
        vecs[6]  = '{5'd0,  32'd32767,      16'h7fff,    0};
        vecs[7]  = '{5'd4,  32'd24,         16'd2,       0};
        vecs[8]  = '{5'd4,  -32'sd24,       -16'sd1,     0};
        vecs[9]  = '{5'd31, 32'h7fffffff,   16'd1,       0};
        vecs[10] = '{5'd31, 32'h80000000,   -16'sd1,     0};
        vecs[11] = '{5'd8,  32'h7fffffff,   16'h7fff,    1};

        // Reset and idle outputs
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst_hold");
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle("rst_release");

        // Single-element vectors: value, tag, exact 2-cycle latency, sat_count
        for (int v = 0; v < NVEC; v++) begin
            reset_dut();
            start_run(int'(vecs[v].sh));
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data = vecs[v].din;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", v), 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_lat_t0", v), 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_lat_t1", v), 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_lat_t2", v), 64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d_data", v), 64'(bus.out_data), 64'(vecs[v].dout));
            check($sformatf("vec%0d_rowcol", v), 64'({bus.out_row, bus.out_col, bus.out_last}), 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_popped", v), 64'(bus.out_valid), 64'd0);
            check($sformatf("vec%0d_sat", v), 64'(sat_count), 64'(vecs[v].sat));
        end

        // Rounding stream through the scoreboard
        reset_dut();
        start_run(1);
        mon_en = 1'b1;
        bus.out_ready = 1'b1;
        send_word(32'd5);
        send_word(-32'sd5);
        send_word(32'd4);
        drain("round");
        check("round_pops", 64'(pops), 64'd3);

        // Saturation stream, then reset with three elements queued
        reset_dut();
        start_run(0);
        mon_en = 1'b1;
        bus.out_ready = 1'b1;
        send_word(32'd40000);
        send_word(-32'sd40000);
        send_word(32'd32767);
        drain("sat");
        check("sat_pops", 64'(pops), 64'd3);
        check("sat_count_two", 64'(sat_count), 64'd2);
        bus.out_ready = 1'b0;
        send_word(32'd40000);
        send_word(32'd1);
        send_word(32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pre_valid", 64'(bus.out_valid), 64'd1);
        check("midrst_pre_sat", 64'(sat_count), 64'd3);
        check("midrst_pre_busy", 64'(busy), 64'd1);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_async_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_async_sat", 64'(sat_count), 64'd0);
        check("midrst_async_state", 64'(state_dbg), 64'd0);
        @(posedge clk); #1;
        check_idle("midrst_next");
        rst = 1'b1;
        @(posedge clk); #1;

        // Backpressure: consumer stalled while the producer keeps offering
        reset_dut();
        start_run(0);
        mon_en = 1'b1;
        bus.out_ready = 1'b0;
        accepts = 0;
        bus.in_valid = 1'b1;
        bus.in_data = small_word();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            xfer = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (xfer) begin
                accepts++;
                bus.in_data = small_word();
            end
        end
        check("bp_accepts", 64'(accepts), 64'(FIFO_DEPTH));
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        check("bp_ready_returns", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain("bp");
        check("bp_pops", 64'(pops), 64'(FIFO_DEPTH + 1));

        // Full randomized run with random backpressure and a stray start
        reset_dut();
        start_run(5);
        mon_en = 1'b1;
        sent = 0;
        poked = 1'b0;
        poke_checked = 1'b0;
        for (int c = 0; c < 20000 && sent < N * N; c++) begin
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : small_word();
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (sent == 50 && !poked) begin
                start = 1'b1;
                shift = 5'd0;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            xfer = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (poked && !poke_checked) begin
                check("start_ignored_state", 64'(state_dbg), 64'd1);
                poke_checked = 1'b1;
            end
            if (xfer) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        start = 1'b0;
        check("full_sent", 64'(sent), 64'(N * N));
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        d = done_cyc - last_pop_cyc;
        check("full_done_once", 64'(done_cnt), 64'd1);
        check("full_pops", 64'(pops), 64'(N * N));
        check("full_queue_empty", 64'(exp_q.size()), 64'd0);
        check("full_done_after_pop", 64'(d >= 1 && d <= 2), 64'd1);
        check("full_idle_state", 64'(state_dbg), 64'd0);
        check("full_busy_low", 64'(busy), 64'd0);
        check("full_sat_count", 64'(sat_count), 64'(model_sat));
        check("tag4_row", 64'(tag4[2*IDX_W:IDX_W+1]), 64'd1);
        check("tag4_col", 64'(tag4[IDX_W:1]), 64'd0);
        check("tag16_row", 64'(tag16[2*IDX_W:IDX_W+1]), 64'd0);
        check("tag16_col", 64'(tag16[IDX_W:1]), 64'd4);
        check("tag255_row", 64'(tag255[2*IDX_W:IDX_W+1]), 64'd15);
        check("tag255_col", 64'(tag255[IDX_W:1]), 64'd15);
        check("tag255_last", 64'(tag255[0]), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("sat_count_holds", 64'(sat_count), 64'(model_sat));
        check("no_done_repeat", 64'(done_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Downstream stage of the tiled sparse matmul engine.
- Consumes the 32-bit signed accumulator results one element at a time, in tile order, over a valid/ready stream.
- For each element: rounds, arithmetic-shifts and saturates it to 16-bit signed, tags it with its (row, col) position, and buffers it in a small FIFO that drives a backpressured output stream.
- Counts saturation events for the performance/accuracy counter bank.

Parameters:
- N, 16: matrix dimension; a run is N*N elements.
- TILE, 4: tile edge; N is a multiple of TILE.
- ACC_W, 32: input accumulator width.
- OUT_W, 16: output element width.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low; 0 resets the block.
- start  in  1  one-cycle run request; sampled only in IDLE.
- shift  in  5  right-shift amount (0..31); latched on accepted start.
- in_valid  in  1  accumulator word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  ACC_W  signed accumulator value.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  OUT_W  signed requantized value.
- out_row  out  $clog2(N)  global row index of the head element.
- out_col  out  $clog2(N)  global column index of the head element.
- out_last  out  1  head is element N*N-1 of the run.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse when the run fully drains.
- sat_count  out  32  saturated elements in the current/last run.

Behaviour:
- Reset (rst=0, any time, including mid-run):
  - State becomes IDLE; FIFO, pipeline and index counters are cleared.
  - Outputs: in_ready=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, done=0, sat_count=0.
  - In-flight data is discarded.
- State machine:
  - IDLE --start--> RUN. On this transition: latch shift, clear sat_count, clear index counters.
  - RUN --(N*N-th input accepted)--> FLUSH.
  - FLUSH --(pipeline empty and FIFO empty)--> DONE.
  - DONE --> IDLE unconditionally; done=1 for exactly this one cycle.
  - start is ignored outside IDLE.
- Input handshake:
  - A word transfers when in_valid && in_ready.
  - in_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH), where inflight counts pipeline stages holding data. No input is accepted in FLUSH.
- Ordering:
  - Accepted word k maps to loop order tr, tc (step TILE), then i, j in 0..TILE-1, with j fastest.
  - row = tr+i, col = tc+j. Index counters advance only on an accepted transfer.
- Pipeline, 2 stages:
  - S1 computes r = (in_data + (shift>0 ? 2^(shift-1) : 0)) >>> shift. The add is done in ACC_W+1 bits, so it cannot overflow. Rounding is round-half-up toward +infinity.
  - S2 saturates r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and writes the FIFO.
  - sat_count increments once per element clamped in S2.
- Latency: a word accepted at edge t is at the FIFO head with out_valid=1 after edge t+2, provided the FIFO was empty.
- Output handshake:
  - Head pops when out_valid && out_ready.
  - out_data/out_row/out_col/out_last hold stable while out_valid && !out_ready.
  - A push and a pop in the same cycle on a full FIFO both occur, and the count is unchanged.
  - The FIFO never overflows, because the in_ready credit rule prevents it.
  - Pops on an empty FIFO do not occur (out_valid=0).
- Counters: index counters wrap to 0 at the end of a run. sat_count holds its value after DONE until the next accepted start.

Test Plan:
- Reset/idle: hold rst=0, then release -> all outputs 0, in_ready=0. Assert rst=0 mid-run with 3 elements in FIFO -> out_valid=0 next cycle, state IDLE, sat_count=0.
- Rounding: shift=1; inputs 5, -5, 4 -> outputs 3, -2, 2. shift=0, input -7 -> -7, with latency exactly 2 cycles to out_valid.
- Saturation: shift=0; inputs 40000, -40000, 32767 -> 32767, -32768, 32767; sat_count=2.
- Tagging, N=16, TILE=4: element index 4 -> row1 col0; index 16 -> row0 col4; index 255 -> row15 col15 with out_last=1.
- Backpressure: out_ready=0 for 12 cycles while in_valid=1 -> in_ready drops after FIFO_DEPTH accepts. On release, outputs appear in order with no loss or duplication, and head values stay stable while stalled.
- Full run: 256 random accumulators with random out_ready -> 256 outputs matching the reference model, done pulses once after the last pop, busy falls the same cycle, and start during RUN is ignored.
